uart_baud_ctrl: RTL
===================

Name: uart_baud_ctrl

Overview:
Controller for the UART timing divider: owns the programmable clock-enable divider that paces the UART/FIFO datapath.
- Produces a 16x oversample tick for RX and a 1x baud tick for TX. Both are clock enables, never derived clocks.
- Accepts divisor reconfiguration over a valid/ready handshake and applies it only on a baud-frame boundary, so a character in flight is never stretched or truncated.

Parameters:
- DIV_W, 16, width of divisor and oversample counter.
- OSR, 16, oversample ticks per baud tick (power of two, 4..16).
- DEFAULT_DIV, 651, divisor after reset (100 MHz / (9600*16)).

Ports:
- clk, input, 1, system clock (100 MHz).
- rst, input, 1, synchronous active-high reset.
- en, input, 1, level: 1 = run tick generation, 0 = hold counters cleared.
- cfg_valid, input, 1, new divisor offered.
- cfg_div, input, DIV_W, offered divisor; os_tick period in clk cycles.
- cfg_ready, output, 1, controller can accept cfg_div.
- cfg_ack, output, 1, one-cycle pulse when an accepted divisor becomes active.
- cfg_err, output, 1, one-cycle pulse when an offered divisor is rejected.
- os_tick, output, 1, one-cycle oversample enable.
- baud_tick, output, 1, one-cycle baud enable, coincident with every OSR-th os_tick.
- active_div, output, DIV_W, divisor currently in use.
- running, output, 1, high in RUN or PEND.

Behaviour:
- Reset (synchronous, wins over all inputs):
  - state=IDLE; os_cnt=0; phase=0; shadow=0; active_div=DEFAULT_DIV.
  - cfg_ack=0, cfg_err=0, os_tick=0, baud_tick=0, running=0, cfg_ready=1.
- States:
  - IDLE: counters held at 0; no ticks.
  - RUN: os_cnt increments each cycle.
  - PEND: as RUN, with a shadow divisor waiting to be applied.
- Transitions:
  - IDLE->RUN when en=1.
  - RUN->PEND on an accepted cfg while running.
  - PEND->RUN on baud_tick (apply).
  - RUN/PEND->IDLE when en=0.
- Counter:
  - os_cnt wraps to 0 when os_cnt==active_div-1.
  - os_tick = running && os_cnt==active_div-1, decoded from registers only (no input-to-output combinational path).
  - phase increments on os_tick and wraps at OSR-1.
  - baud_tick = os_tick && phase==OSR-1.
- Latency and period:
  - en sampled high at edge k gives os_cnt=0 after edge k.
  - First os_tick is in the active_div-th cycle of RUN.
  - os_tick period is exactly active_div cycles; baud_tick period is exactly active_div*OSR cycles.
- Handshake:
  - cfg_ready = (state!=PEND). Transfer occurs when cfg_valid && cfg_ready at the edge.
  - cfg_div<2 is rejected: cfg_err pulses the next cycle; no state or divisor change.
  - Accept in IDLE: active_div<=cfg_div at that edge; cfg_ack pulses the next cycle.
  - Accept in RUN: shadow<=cfg_div, state->PEND, cfg_ready drops the next cycle.
  - PEND apply, at the edge ending a baud_tick cycle: active_div<=shadow; os_cnt, phase<=0; state->RUN; cfg_ack pulses the following cycle.
- Simultaneous events:
  - en=0 while in PEND: apply shadow immediately, go IDLE, cfg_ack pulses. en=0 takes priority over a baud boundary in the same cycle.
  - Accept in RUN coinciding with a baud_tick cycle: the divisor is stored in shadow and waits for the next boundary. A transfer is never applied in its own cycle.
  - cfg_valid held high while cfg_ready=0: no transfer; the value is not captured.
- Width rules:
  - os_cnt and shadow are DIV_W; phase is clog2(OSR).
  - Arithmetic is unsigned; wrap compares use active_div-1 (safe because active_div>=2).
- Reset mid-operation: the pending shadow is discarded with no cfg_ack, and DEFAULT_DIV is restored.

Decomposition:
- Package uart_pkg holds:
  - DIV_W, OSR, DEFAULT_DIV, MIN_DIV=2.
  - baud_state_t enum {IDLE, RUN, PEND}.
- Sub-module uart_tick_div is natural. It is the bare enable-counter: clk, rst, clr, div, tick.
- uart_baud_ctrl holds the FSM, shadow register, phase counter and handshake.

Test Plan:
- Reset then en=1 with DEFAULT_DIV=651 -> first os_tick in RUN cycle 651, then every 651 cycles; baud_tick every 10416 cycles; active_div=651.
- In IDLE, cfg_div=10 with cfg_valid for 1 cycle -> active_div=10; cfg_ack one cycle later; then en=1 -> os_tick every 10 cycles, baud_tick every 160.
- RUN at div=10, accept cfg_div=4 mid-frame at phase 5 -> cfg_ready low; ticks stay at period 10 until baud_tick; cfg_ack the next cycle; os_tick period 4 after that, first os_tick 4 cycles after the apply.
- cfg_div=1 and cfg_div=0 offered -> cfg_err pulses each time; active_div unchanged; cfg_ack never asserted.
- PEND with shadow=20, en dropped -> IDLE next cycle; active_div=20; cfg_ack pulses; os_tick and baud_tick stay 0 while en=0.
- RUN with PEND shadow=30, rst pulsed 1 cycle -> active_div=651, all pulses 0, cfg_ready=1; no cfg_ack ever follows.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART baud-rate controller.
package uart_pkg;
    localparam int DIV_W       = 16;
    localparam int OSR         = 16;
    localparam int DEFAULT_DIV = 651;
    localparam int MIN_DIV     = 2;

    typedef enum logic [1:0] {IDLE, RUN, PEND} baud_state_t;
endpackage

// File: rtl/uart_baud_ctrl_if.sv
// Divisor reconfiguration handshake between a host and the baud controller.
interface uart_baud_ctrl_if #(parameter int DIV_W = uart_pkg::DIV_W) ();
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_ack;
    logic             cfg_err;

    modport master (output cfg_valid, cfg_div, input  cfg_ready, cfg_ack, cfg_err);
    modport slave  (input  cfg_valid, cfg_div, output cfg_ready, cfg_ack, cfg_err);
endinterface

// File: rtl/uart_tick_div.sv
// Bare clock-enable divider: tick is high for one cycle every div cycles.
module uart_tick_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;

    // Decoded from registers only; div is always >= 2 so div-1 never underflows.
    assign tick = (cnt == div - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + DIV_W'(1);
    end
endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud controller: oversample/baud enables plus frame-aligned divisor updates.
module uart_baud_ctrl #(
    parameter int DIV_W       = uart_pkg::DIV_W,
    parameter int OSR         = uart_pkg::OSR,
    parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    uart_baud_ctrl_if.slave  cfg,
    output logic             os_tick,
    output logic             baud_tick,
    output logic [DIV_W-1:0] active_div,
    output logic             running
);
    import uart_pkg::*;

    localparam int PH_W = $clog2(OSR);

    baud_state_t      state, state_n;
    logic [DIV_W-1:0] shadow;
    logic [PH_W-1:0]  phase;
    logic             div_tick, clr;
    logic             xfer, bad, take;
    logic             load_now, load_shadow, apply;

    uart_tick_div #(.DIV_W(DIV_W)) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .div  (active_div),
        .tick (div_tick)
    );

    assign running       = (state != IDLE);
    assign os_tick       = running && div_tick;
    assign baud_tick     = os_tick && (phase == PH_W'(OSR - 1));
    assign cfg.cfg_ready = (state != PEND);
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
    assign bad           = (cfg.cfg_div < DIV_W'(MIN_DIV));
    assign take          = xfer && !bad;
    assign clr           = (state == IDLE) || !en || apply;

    always_comb begin
        state_n     = state;
        load_now    = 1'b0;
        load_shadow = 1'b0;
        apply       = 1'b0;
        case (state)
            IDLE: begin
                load_now = take;
                if (en) state_n = RUN;
            end
            RUN: begin
                // Stopping means no character is in flight, so a new divisor can land at once.
                if (!en) begin
                    state_n  = IDLE;
                    load_now = take;
                end else if (take) begin
                    load_shadow = 1'b1;
                    state_n     = PEND;
                end
            end
            PEND: begin
                if (!en) begin
                    apply   = 1'b1;
                    state_n = IDLE;
                end else if (baud_tick) begin
                    apply   = 1'b1;
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            phase       <= '0;
            active_div  <= DIV_W'(DEFAULT_DIV);
            cfg.cfg_ack <= 1'b0;
            cfg.cfg_err <= 1'b0;
        end else begin
            state       <= state_n;
            cfg.cfg_ack <= load_now || apply;
            cfg.cfg_err <= xfer && bad;
            if (load_shadow) shadow <= cfg.cfg_div;
            if (load_now)
                active_div <= cfg.cfg_div;
            else if (apply)
                active_div <= shadow;
            if (clr)
                phase <= '0;
            else if (os_tick)
                phase <= (phase == PH_W'(OSR - 1)) ? '0 : phase + PH_W'(1);
        end
    end
endmodule
